// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared codes for the EX-stage ALU control and the iterative multiply/divide engine.
// Pure constants and combinational helpers; no state, no handshake.
package alu_muldiv_ctrl_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SLL = 4'b0011;
  localparam logic [3:0] ALUOP_SRL = 4'b0100;
  localparam logic [3:0] ALUOP_SRA = 4'b0101;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_SLT = 4'b0111;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;
  localparam logic [3:0] ALUOP_XOR = 4'b1101;

  localparam logic [1:0] ALU_CTL_ADD  = 2'b00;
  localparam logic [1:0] ALU_CTL_SUB  = 2'b01;
  localparam logic [1:0] ALU_CTL_FUNC = 2'b10;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  // Operation latched at start; sa/sb are operand signs (always 0 for unsigned ops).
  typedef struct packed {
    logic is_div;
    logic sa;
    logic sb;
  } md_op_t;

  function automatic logic is_md_class(input logic [5:0] f);
    return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                     FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_md_calc(input logic [5:0] f);
    return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic [3:0] decode_func(input logic [5:0] f);
    logic [3:0] op;
    case (f)
      FN_SLL:  op = ALUOP_SLL;
      FN_SRL:  op = ALUOP_SRL;
      FN_SRA:  op = ALUOP_SRA;
      FN_ADD:  op = ALUOP_ADD;
      FN_SUB:  op = ALUOP_SUB;
      FN_AND:  op = ALUOP_AND;
      FN_OR:   op = ALUOP_OR;
      FN_XOR:  op = ALUOP_XOR;
      FN_NOR:  op = ALUOP_NOR;
      FN_SLT:  op = ALUOP_SLT;
      default: op = ALUOP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider; one bit per cycle, result WIDTH+2 edges after go.
// go is only honoured in IDLE; busy covers the whole CALC+FIX window, wr/done follow FIX.
module muldiv_iter
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr,
  output logic [WIDTH-1:0] wr_hi,
  output logic [WIDTH-1:0] wr_lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  md_op_t             op;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               sa_in, sb_in;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sa_in   = sgn & a[WIDTH-1];
    sb_in   = sgn & b[WIDTH-1];
    abs_a   = sa_in ? -a : a;
    abs_b   = sb_in ? -b : b;
    // Multiply: acc[WIDTH-1:0] holds the unconsumed multiplier bits, opnd the multiplicand.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    shifted = {rem, acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    prod    = (op.sa ^ op.sb) ? -acc : acc;
    // Divide by zero leaves quotient all-ones and remainder |a|; the remainder
    // sign fixup then restores the raw dividend, so only the quotient skips fixup.
    if (opnd == '0)
      quo_fix = '1;
    else
      quo_fix = (op.sa ^ op.sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix = op.sa ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op    <= '0;
      opnd  <= '0;
      acc   <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (go) begin
            op.is_div <= is_div;
            op.sa     <= sa_in;
            op.sb     <= sb_in;
            opnd      <= is_div ? abs_b : abs_a;
            acc       <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
            rem       <= '0;
            cnt       <= '0;
            state     <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (op.is_div) begin
            rem              <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
          end
          if (cnt == LAST)
            state <= MD_FIX;
          else
            cnt <= cnt + CNT_W'(1);
        end
        MD_FIX: begin
          done  <= 1'b1;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state != MD_IDLE);
  assign wr    = (state == MD_FIX);
  assign wr_hi = op.is_div ? rem_fix : prod[2*WIDTH-1:WIDTH];
  assign wr_lo = op.is_div ? quo_fix : prod[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decode plus HI/LO unit; decode is combinational, MULT/DIV take WIDTH+2 edges.
// HI/LO-class instructions presented while busy raise stall and are dropped, never queued.
module alu_muldiv_ctrl
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op_in,
  input  logic [5:0]       func,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alu_op_out,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result
);

  logic             func_op;
  logic             md_go, md_is_div, md_sgn;
  logic             mt_hi, mt_lo;
  logic             md_wr;
  logic [WIDTH-1:0] md_hi, md_lo;

  always_comb begin
    case (alu_op_in)
      ALU_CTL_ADD:  alu_op_out = ALUOP_ADD;
      ALU_CTL_SUB:  alu_op_out = ALUOP_SUB;
      ALU_CTL_FUNC: alu_op_out = decode_func(func);
      default:      alu_op_out = ALUOP_ADD;
    endcase
  end

  assign func_op   = (alu_op_in == ALU_CTL_FUNC);
  assign md_go     = start & func_op & ~busy & is_md_calc(func);
  assign md_is_div = (func == FN_DIV) | (func == FN_DIVU);
  assign md_sgn    = (func == FN_MULT) | (func == FN_DIV);
  assign mt_hi     = start & func_op & ~busy & (func == FN_MTHI);
  assign mt_lo     = start & func_op & ~busy & (func == FN_MTLO);
  assign stall     = busy & start & is_md_class(func);

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv_iter (
    .clk    (clk),
    .reset  (reset),
    .go     (md_go),
    .is_div (md_is_div),
    .sgn    (md_sgn),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .wr     (md_wr),
    .wr_hi  (md_hi),
    .wr_lo  (md_lo)
  );

  // MT writes can never collide with an engine write: the engine only writes while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (md_wr) begin
      hi <= md_hi;
      lo <= md_lo;
    end else begin
      if (mt_hi) hi <= a;
      if (mt_lo) lo <= a;
    end
  end

  always_comb begin
    if (func == FN_MFHI)
      mf_result = hi;
    else if (func == FN_MFLO)
      mf_result = lo;
    else
      mf_result = '0;
  end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl at WIDTH=32 and WIDTH=8 with a HI/LO result scoreboard.
module tb_alu_muldiv_ctrl;
  import alu_muldiv_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op_in;
  logic [5:0]  func;
  logic        start, start8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;

  logic [3:0]  alu_op_out, alu_op_out8;
  logic        busy, done, stall, busy8, done8, stall8;
  logic [31:0] hi, lo, mf_result;
  logic [7:0]  hi8, lo8, mf_result8;

  res_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .alu_op_in(alu_op_in), .func(func), .start(start),
    .a(a), .b(b), .alu_op_out(alu_op_out), .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo), .mf_result(mf_result)
  );

  alu_muldiv_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .alu_op_in(alu_op_in), .func(func), .start(start8),
    .a(a8), .b(b8), .alu_op_out(alu_op_out8), .busy(busy8), .done(done8), .stall(stall8),
    .hi(hi8), .lo(lo8), .mf_result(mf_result8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one MULT/DIV-class start for a single edge and record the expected HI/LO.
  task automatic issue(input bit w8, input logic [5:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    res_t r;
    alu_op_in = 2'b10;
    func      = f;
    a         = av;
    b         = bv;
    a8        = av[7:0];
    b8        = bv[7:0];
    if (w8) start8 = 1'b1;
    else    start  = 1'b1;
    r.hi = eh;
    r.lo = el;
    sb_q.push_back(r);
    tick();
    start  = 1'b0;
    start8 = 1'b0;
    func   = 6'h20;
  endtask

  // Entered one cycle after the accepting edge; counts busy cycles and scores the result.
  task automatic run_md(input string tag, input bit w8, input int exp_busy);
    int   n;
    res_t e;
    n = 0;
    while ((w8 ? busy8 : busy) === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, "_done"}, 64'(w8 ? done8 : done), 64'(1));
    check({tag, "_sb_pending"}, 64'(sb_q.size() != 0), 64'(1));
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    check({tag, "_hi"}, w8 ? 64'(hi8) : 64'(hi), 64'(e.hi));
    check({tag, "_lo"}, w8 ? 64'(lo8) : 64'(lo), 64'(e.lo));
    tick();
    check({tag, "_done_pulse_end"}, 64'(w8 ? done8 : done), 64'(0));
  endtask

  logic [11:0] dec_tab [8];
  res_t        first;

  initial begin
    dec_tab = '{{2'b10, 6'h2A, ALUOP_SLT}, {2'b10, 6'h3F, ALUOP_ADD},
                {2'b01, 6'h00, ALUOP_SUB}, {2'b00, 6'h22, ALUOP_ADD},
                {2'b11, 6'h22, ALUOP_ADD}, {2'b10, 6'h03, ALUOP_SRA},
                {2'b10, 6'h27, ALUOP_NOR}, {2'b10, 6'h18, ALUOP_ADD}};

    reset = 1'b0; start = 1'b0; start8 = 1'b0;
    alu_op_in = 2'b00; func = 6'h20; a = '0; b = '0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy8", 64'(busy8), 64'(0));
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      alu_op_in = dec_tab[i][11:10];
      func      = dec_tab[i][9:4];
      #1;
      check($sformatf("decode_%0d", i), 64'(alu_op_out), 64'(dec_tab[i][3:0]));
    end
    tick();

    issue(1'b0, 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("mult_neg", 1'b0, 33);
    issue(1'b0, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("multu_max", 1'b0, 33);
    issue(1'b0, 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_neg", 1'b0, 33);
    issue(1'b0, 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("divu", 1'b0, 33);
    issue(1'b0, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_md("div_ovf", 1'b0, 33);
    issue(1'b0, 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_md("divu_zero", 1'b0, 33);
    issue(1'b0, 6'h1A, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF);
    run_md("div_zero_neg", 1'b0, 33);

    alu_op_in = 2'b10; func = 6'h11; a = 32'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'(32'h1234));
    check("mthi_lo_kept", 64'(lo), 64'(32'hFFFFFFFF));
    check("mthi_busy", 64'(busy), 64'(0));
    func = 6'h13; a = 32'hBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'(32'hBEEF));
    check("mtlo_done", 64'(done), 64'(0));
    func = 6'h10; #1;
    check("mfhi", 64'(mf_result), 64'(32'h1234));
    func = 6'h12; #1;
    check("mflo", 64'(mf_result), 64'(32'hBEEF));
    func = 6'h20; #1;
    check("mf_other", 64'(mf_result), 64'(0));

    // Back-to-back MULT: cycle 1 is the cycle after the accepting edge.
    issue(1'b0, 6'h18, 32'd5, 32'd6, 32'd0, 32'd30);
    start = 1'b1; func = 6'h18; a = 32'd9; b = 32'd9; #1;
    check("stall_c1", 64'(stall), 64'(1));
    func = 6'h20; #1;
    check("nostall_add", 64'(stall), 64'(0));
    func = 6'h11; #1;
    check("stall_mthi", 64'(stall), 64'(1));
    tick();
    start = 1'b0;
    repeat (31) tick();
    check("c33_busy", 64'(busy), 64'(1));
    start = 1'b1; func = 6'h18; #1;
    check("stall_c33", 64'(stall), 64'(1));
    tick();
    start = 1'b0; func = 6'h12; #1;
    check("c34_done", 64'(done), 64'(1));
    check("c34_busy", 64'(busy), 64'(0));
    check("c34_sb_pending", 64'(sb_q.size() != 0), 64'(1));
    first = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    check("c34_hi", 64'(hi), 64'(first.hi));
    check("c34_mflo", 64'(mf_result), 64'(first.lo));
    issue(1'b0, 6'h18, 32'd9, 32'd9, 32'd0, 32'd81);
    run_md("mult_second", 1'b0, 33);

    alu_op_in = 2'b10; func = 6'h1A; a = 32'd100; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; func = 6'h20;
    repeat (10) tick();
    check("div_mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    repeat (3) tick();
    check("abort_no_late_done", 64'(done), 64'(0));
    check("abort_no_late_lo", 64'(lo), 64'(0));

    issue(1'b1, 6'h18, 32'h7F, 32'h7F, 32'h3F, 32'h01);
    run_md("w8_mult", 1'b1, 9);
    issue(1'b1, 6'h1A, 32'h80, 32'hFF, 32'h00, 32'h80);
    run_md("w8_div_ovf", 1'b1, 9);
    check("w32_idle_during_w8", 64'(busy), 64'(0));
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Keeps the combinational func to ALU-op decode for single-cycle R-type and I-type operations.
- Adds a multi-cycle iterative multiply/divide engine with HI/LO registers and a busy/stall handshake to the pipeline.
- Sits in EX stage: decode output drives the ALU; HI/LO results feed MFHI/MFLO writeback.

Parameters:
- WIDTH, 32, operand, HI and LO width; must be 8 or more.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge resets all state.
- alu_op_in  in  2  00 add, 01 sub, 10 decode func, 11 reserved.
- func  in  6  R-type function field.
- start  in  1  valid R-type instruction present in EX this cycle.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- alu_op_out  out  4  ALUOP_* code for the single-cycle ALU.
- busy  out  1  iterative multiply/divide in progress.
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
- stall  out  1  hold EX: HI/LO-class instruction presented while busy.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mf_result  out  WIDTH  hi for FN_MFHI, lo for FN_MFLO, else 0; combinational.

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts it with no HI/LO write.
- alu_op_out (combinational):
  - 00 gives ALUOP_ADD; 01 gives ALUOP_SUB.
  - 10 decodes SLL, SRL, SRA, ADD, SUB, AND, OR, XOR, NOR, SLT as before.
  - Any other func, or alu_op_in 11, gives ALUOP_ADD. No simulation messages.
- md-class funcs: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13, MFHI 0x10, MFLO 0x12.
- FSM states:
  - IDLE: start with MULT/MULTU/DIV/DIVU and alu_op_in==10 latches operands, the signed flag and the op, clears the counter, goes to CALC. Signed ops latch magnitudes |a| and |b| and record result signs.
  - CALC: one iteration per cycle, WIDTH cycles. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring: one quotient bit per cycle, with a WIDTH+1-bit partial remainder. After the count reaches WIDTH-1, go to FIX.
  - FIX: apply sign fixup (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa). Write hi/lo, set done=1 for the next cycle, go to IDLE.
- Latency and handshake:
  - Start accepted at edge k: busy=1 after edges k..k+WIDTH, i.e. WIDTH+1 cycles.
  - After edge k+WIDTH+1: busy=0, done=1, new hi/lo visible.
  - done is high exactly one cycle.
- MTHI/MTLO in IDLE: hi (or lo) is written with a at the next edge. No busy, no done.
- stall = busy & start & (func is md-class). md-class starts while busy are ignored, not queued. Non-md instructions never stall.
- Same-edge events: start in the FIX cycle still stalls, because busy is high. The instruction is accepted the next cycle in IDLE. MFHI in the done cycle reads the new value.
- Divide by zero, with no exception raised:
  - lo = all-ones, hi = a, written raw; sign fixup is skipped.
  - DIVU and DIV give identical results.
- Signed overflow DIV of min by -1: lo = min, hi = 0.
- Multiply: {hi, lo} is the full 2*WIDTH product. Divide: lo = quotient, hi = remainder.

Decomposition:
- Add to defines.v:
  - FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO.
  - FSM encodings MD_IDLE, MD_CALC, MD_FIX.
  - Existing ALUOP_* and FN_* remain.
- One sub-module, muldiv_iter:
  - Contains the FSM, counter, accumulator and sign fixup, with start/busy/done plus hi/lo write outputs.
  - The top module keeps the alu_op_out decode, MT/MF handling and the stall logic.

Test Plan:
1. Decode: alu_op_in=10, func=FN_SLT -> ALUOP_SLT. func=0x3F -> ALUOP_ADD. alu_op_in=01 -> ALUOP_SUB.
2. MULT with WIDTH=32, a=-3 (0xFFFFFFFD), b=7 -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU of 0xFFFFFFFF squared -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 by -1 -> lo=0x80000000, hi=0.
4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
5. MULT started; second MULT presented at cycles 1, 33 and 34 -> stall=1 in 1 and 33, first result unaffected. Accepted at cycle 34; MFLO in the done cycle returns the first lo.
6. reset=0 asserted at iteration 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0. WIDTH=8 regression: MULT 0x7F*0x7F -> hi=0x3F, lo=0x01, busy 9 cycles.
